// File: rtl/audio_pkg.sv
// Shared types and defaults for the buffered I2S transmitter.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } play_state_e;

  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_BCLK_DIV = 8;

  // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock FIFO with flush and registered occupancy; push/pop are trusted
// to respect full/empty (the caller resolves simultaneous push/pop when full).
module audio_sync_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_SAMPLE_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wr_data,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;

  assign rd_data = mem[rd_ptr_r];
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == LW'(0));

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level    <= LW'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level    <= LW'(0);
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset because empty slots are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/audio_i2s_fifo_tx.sv
// Buffered I2S transmitter with priming, underrun/overflow pulses and mono mode.
// Define AUDIO_I2S_LEFT_JUSTIFIED_EN for left-justified lrck alignment.
module audio_i2s_fifo_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int BCLK_DIV    = DEF_BCLK_DIV,
  parameter int PRIME_LEVEL = 4,
  parameter int REQ_LEVEL   = 8
) (
  input  logic                      mon_clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  input  logic [2*SAMPLE_W-1:0]     wr_data,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      mono,
  output logic                      audio_req,
  output logic                      underrun,
  output logic                      overflow,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      bclk,
  output logic                      lrck,
  output logic                      sdata
);

  localparam int WW = 2 * SAMPLE_W;
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(WW);
  localparam int LW = level_w(DEPTH);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] B_LAST   = BW'(WW - 1);

  play_state_e       state, state_next;
  logic [DW-1:0]     div_cnt, div_next;
  logic [BW-1:0]     b_cnt, b_next;
  logic [WW-1:0]     shreg;
  logic              mono_b;
  logic [SAMPLE_W-1:0] mono_lo;
  logic              armed;

  logic              fall_evt, frame_start, flush;
  logic              pop, play_b, under_s, wr_acc, drop, req_fire;
  logic              full, empty;
  logic [WW-1:0]     rd_data, pop_word, frame_word;
  logic [LW-1:0]     level_next;

  function automatic logic lr_of(input logic [BW-1:0] b);
`ifdef AUDIO_I2S_LEFT_JUSTIFIED_EN
    return (b >= BW'(SAMPLE_W));
`else
    return (b >= BW'(SAMPLE_W - 1)) && (b <= BW'(WW - 2));
`endif
  endfunction

  assign fall_evt    = (div_cnt == DIV_LAST);
  assign frame_start = fall_evt && (b_cnt == B_LAST);
  assign flush       = start || stop;
  assign div_next    = fall_evt ? DW'(0) : div_cnt + DW'(1);
  assign b_next      = (b_cnt == B_LAST) ? BW'(0) : b_cnt + BW'(1);

  // A pop in mono mode plays the upper half now and keeps the lower half for frame B.
  assign pop_word   = mono ? {rd_data[WW-1:SAMPLE_W], rd_data[WW-1:SAMPLE_W]} : rd_data;
  assign frame_word = pop ? pop_word : (play_b ? {mono_lo, mono_lo} : {WW{1'b0}});

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign wr_acc   = wr_valid && (state != IDLE) && !flush && (!full || pop);
  assign drop     = wr_valid && (state != IDLE) && !flush && full && !pop;
  assign req_fire = frame_start && !flush && (state != IDLE) && armed &&
                    (level_next <= LW'(REQ_LEVEL));

  // Next state and frame-start decisions; stop outranks start.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    play_b     = 1'b0;
    under_s    = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else if (start) begin
      state_next = PRIME;
    end else if (frame_start) begin
      case (state)
        IDLE: state_next = IDLE;
        PRIME: begin
          if (level >= LW'(PRIME_LEVEL)) begin
            state_next = PLAY;
            pop        = 1'b1;
          end else begin
            state_next = PRIME;
          end
        end
        PLAY: begin
          if (mono_b) begin
            play_b = 1'b1;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            under_s = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  // Predicted occupancy after this cycle, used for the refill decision.
  always_comb begin
    case ({wr_acc, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // State register.
  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Pending mono frame B; any flush discards it.
  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset) begin
      mono_b  <= 1'b0;
      mono_lo <= {SAMPLE_W{1'b0}};
    end else if (flush) begin
      mono_b  <= 1'b0;
      mono_lo <= mono_lo;
    end else if (frame_start) begin
      mono_b  <= pop && mono;
      mono_lo <= pop ? rd_data[SAMPLE_W-1:0] : mono_lo;
    end else begin
      mono_b  <= mono_b;
      mono_lo <= mono_lo;
    end
  end

  // Bit clock divider, bit counter, word select and serial shifter.
  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset) begin
      div_cnt <= DW'(0);
      bclk    <= 1'b0;
      b_cnt   <= BW'(0);
      lrck    <= 1'b0;
      sdata   <= 1'b0;
      shreg   <= {WW{1'b0}};
    end else begin
      div_cnt <= div_next;
      bclk    <= (div_next >= DIV_HALF);
      if (fall_evt) begin
        b_cnt <= b_next;
        lrck  <= lr_of(b_next);
        if (frame_start) begin
          sdata <= frame_word[WW-1];
          shreg <= frame_word << 1;
        end else begin
          sdata <= shreg[WW-1];
          shreg <= shreg << 1;
        end
      end
    end
  end

  // Status pulses and the single-outstanding refill request.
  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset) begin
      audio_req <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      audio_req <= req_fire;
      underrun  <= under_s;
      overflow  <= drop;
      if (start || wr_acc) armed <= 1'b1;
      else if (req_fire)   armed <= 1'b0;
      else                 armed <= armed;
    end
  end

  audio_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (mon_clk),
    .reset   (reset),
    .flush   (flush),
    .push    (wr_acc),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

endmodule

// File: tb/tb_audio_i2s_fifo_tx.sv
// Directed bench: frames are captured bit by bit at fixed cycle offsets from reset
// release (frame m starts at edge 256*m with default parameters).
module tb_audio_i2s_fifo_tx;

  logic        mon_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data  = 32'h0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        mono  = 1'b0;
  logic        audio_req, underrun, overflow, bclk, lrck, sdata;
  logic [4:0]  level;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int req_cnt = 0;
  int und_cnt = 0;
  int ovf_cnt = 0;

`ifdef AUDIO_I2S_LEFT_JUSTIFIED_EN
  localparam logic [31:0] LR_EXP = 32'h0000_FFFF;
`else
  localparam logic [31:0] LR_EXP = 32'h0001_FFFE;
`endif

  audio_i2s_fifo_tx dut (
    .mon_clk   (mon_clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .mono      (mono),
    .audio_req (audio_req),
    .underrun  (underrun),
    .overflow  (overflow),
    .level     (level),
    .bclk      (bclk),
    .lrck      (lrck),
    .sdata     (sdata)
  );

  always #5 mon_clk = ~mon_clk;

  always @(negedge mon_clk) begin
    if (!reset) begin
      if (audio_req) req_cnt++;
      if (underrun)  und_cnt++;
      if (overflow)  ovf_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge mon_clk);
    cyc++;
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic write_word(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Captures frame m (starting at edge n0) and checks data and word select.
  task automatic check_frame(input string tag, input int n0, input logic [31:0] exp);
    logic [31:0] d;
    logic [31:0] l;
    for (int j = 0; j < 32; j++) begin
      goto(n0 + 8 * j + 4);
      d[31 - j] = sdata;
      l[31 - j] = lrck;
    end
    check_eq({tag, "_data"}, d, exp);
    check_eq({tag, "_lrck"}, l, LR_EXP);
  endtask

  initial begin
    repeat (3) @(posedge mon_clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Reset state
    check_eq("rst_bclk",  {31'h0, bclk},      32'h0);
    check_eq("rst_lrck",  {31'h0, lrck},      32'h0);
    check_eq("rst_sdata", {31'h0, sdata},     32'h0);
    check_eq("rst_req",   {31'h0, audio_req}, 32'h0);
    check_eq("rst_flags", {30'h0, underrun, overflow}, 32'h0);
    check_eq("rst_level", {27'h0, level},     32'h0);

    // Idle: bclk period 8, lrck edges at fixed bit positions, silent line
    for (int i = 1; i <= 16; i++) begin
      goto(i);
      check_eq("idle_bclk", {31'h0, bclk}, ((i % 8) >= 4) ? 32'h1 : 32'h0);
    end
    begin
      int bs[5];
      bs = '{14, 15, 16, 30, 31};
      for (int k = 0; k < 5; k++) begin
        goto(8 * bs[k] + 2);
        check_eq("idle_lrck", {31'h0, lrck}, {31'h0, LR_EXP[31 - bs[k]]});
        check_eq("idle_sdata", {31'h0, sdata}, 32'h0);
      end
    end
    goto(250);
    check_eq("idle_req", req_cnt, 0);

    // Prime with four words; playback starts at the next frame
    goto(259); pulse_start();
    goto(261);
    write_word(32'hA5A5_0F0F);
    write_word(32'h1111_2222);
    write_word(32'h3333_4444);
    write_word(32'h5555_6666);
    check_eq("prime_level", {27'h0, level}, 32'd4);
    goto(512);
    check_eq("req_pulse_hi", {31'h0, audio_req}, 32'h1);
    check_eq("play_level",   {27'h0, level},     32'd3);
    goto(513);
    check_eq("req_pulse_lo", {31'h0, audio_req}, 32'h0);
    check_frame("f2", 512, 32'hA5A5_0F0F);
    check_frame("f3", 768, 32'h1111_2222);
    check_eq("req_disarmed", req_cnt, 1);

    // A write re-arms the request; the next drain fires it again
    goto(1020); write_word(32'hCAFE_BEEF);
    check_frame("f4", 1024, 32'h3333_4444);
    check_eq("req_rearmed", req_cnt, 2);
    check_frame("f5", 1280, 32'h5555_6666);
    check_frame("f6", 1536, 32'hCAFE_BEEF);

    // Underrun: silent frame, one pulse, stays in PLAY
    goto(1792);
    check_eq("und_hi", {31'h0, underrun}, 32'h1);
    goto(1793);
    check_eq("und_lo", {31'h0, underrun}, 32'h0);
    check_frame("f7", 1792, 32'h0);
    check_eq("und_cnt1", und_cnt, 1);
    goto(2044); write_word(32'h0BAD_F00D);
    check_eq("wr_level", {27'h0, level}, 32'd1);
    check_frame("f8", 2048, 32'h0BAD_F00D);
    check_eq("req_cnt3", req_cnt, 3);

    // Overflow around a full-FIFO pop
    goto(2304);
    check_eq("und_hi2", {31'h0, underrun}, 32'h1);
    goto(2310);
    for (int i = 0; i < 16; i++) write_word({16'h1000 + 16'(i), 16'h2000 + 16'(i)});
    check_eq("full_level", {27'h0, level}, 32'd16);
    goto(2558);
    write_word(32'hBAD0_0000);
    check_eq("ovf_1", {31'h0, overflow}, 32'h1);
    write_word(32'hD00D_0001);
    check_eq("ovf_pop", {31'h0, overflow}, 32'h0);
    write_word(32'hBAD0_0002);
    check_eq("ovf_2", {31'h0, overflow}, 32'h1);
    check_eq("ovf_level", {27'h0, level}, 32'd16);
    check_frame("f10", 2560, 32'h1000_2000);
    check_eq("ovf_cnt", ovf_cnt, 2);

    // Stop flushes; restart in mono
    goto(2820); pulse_stop();
    check_eq("stop_level", {27'h0, level}, 32'd0);
    goto(2822); pulse_start();
    mono = 1'b1;
    write_word(32'h1234_5678);
    write_word(32'h9ABC_DEF0);
    write_word(32'h0F0F_F0F0);
    write_word(32'h5A5A_A5A5);
    goto(3073);
    check_eq("mono_level_a", {27'h0, level}, 32'd3);
    mono = 1'b0;
    check_frame("f12", 3072, 32'h1234_1234);
    goto(3329);
    check_eq("mono_level_b", {27'h0, level}, 32'd3);
    check_frame("f13", 3328, 32'h5678_5678);
    mono = 1'b1;
    goto(3590); pulse_stop();
    goto(3592);
    check_eq("stop2_level", {27'h0, level}, 32'd0);
    check_frame("f15", 3840, 32'h0);

    check_eq("req_total", req_cnt, 4);
    check_eq("und_total", und_cnt, 2);
    check_eq("ovf_total", ovf_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_i2s_fifo_tx.md
Name: audio_i2s_fifo_tx

Overview:
Buffered, parametrised I2S transmitter for the sound-box path. It accepts 32-bit audio words decoded from monitor packets and buffers them in a FIFO. It serialises the buffered samples as I2S with an internally divided BCLK, and emits refill requests toward the op encoder. It generalises the fixed stereo-16/Divider8 sender with these additions:
- configurable sample width, depth and divider;
- a mono mode;
- priming, underrun and overflow handling.

Parameters:
SAMPLE_W, 16, bits per channel sample; one FIFO word = 2*SAMPLE_W bits.
DEPTH, 16, FIFO words; power of 2, at least 4.
BCLK_DIV, 8, mon_clk cycles per BCLK period; even, at least 2.
PRIME_LEVEL, 4, words required before playback starts; 1..DEPTH.
REQ_LEVEL, 8, audio_req fires when level <= REQ_LEVEL; must be less than DEPTH.

Ports:
mon_clk  in  1  sole clock
reset  in  1  asynchronous, active-high reset
wr_valid  in  1  one-cycle strobe: wr_data carries an audio word
wr_data  in  2*SAMPLE_W  [2W-1:W] left (or first mono sample), [W-1:0] right (or second mono sample)
start  in  1  one-cycle pulse: flush the FIFO and begin priming
stop  in  1  one-cycle pulse: return to IDLE and flush
mono  in  1  mono mode; sampled at each word fetch
audio_req  out  1  one-cycle refill request pulse
underrun  out  1  one-cycle pulse: word needed while FIFO empty
overflow  out  1  one-cycle pulse: write dropped while FIFO full
level  out  $clog2(DEPTH)+1  FIFO occupancy
bclk  out  1  I2S bit clock
lrck  out  1  I2S word select; 0 = left
sdata  out  1  I2S serial data, MSB first

Behaviour:
- Reset: all outputs 0; divider, bit counter and FIFO pointers 0; state IDLE. Reset asserted mid-frame aborts the frame immediately.
- Divider: counter runs 0..BCLK_DIV-1. bclk = 0 for counts below BCLK_DIV/2, else 1, registered. A "fall event" occurs on the cycle the counter wraps to 0. The divider runs in every state.
- Bit counter b: 0..2*SAMPLE_W-1, advances on each fall event and wraps to 0.
- lrck = 1 for b in [SAMPLE_W-1, 2*SAMPLE_W-2], else 0. This gives the standard I2S one-bit lead.
- sdata is updated only on fall events, from a shift register: slot bit SAMPLE_W-1-b for b < SAMPLE_W, otherwise bit 2*SAMPLE_W-1-b.
- Word fetch occurs on the fall event where b wraps to 0, and loads the frame that starts on that event.
- States:
  - IDLE: loads zeros; FIFO held empty; writes dropped silently (no overflow pulse); audio_req held 0. start → PRIME.
  - PRIME: writes accepted; frames output zeros; no pops. When level >= PRIME_LEVEL at a frame start → PLAY, and that frame pops.
  - PLAY: at frame start, pops if the FIFO is non-empty. If empty: load zeros and pulse underrun; remain in PLAY.
  - stop in any state → IDLE and flush. start in any state → flush and PRIME. start and stop in the same cycle: stop wins.
- Stereo frame: left = word[2W-1:W], right = word[W-1:0]; one pop per frame.
- Mono:
  - A popped word supplies two frames. Frame A plays [2W-1:W] on both channels; frame B plays [W-1:0] on both channels, with no pop.
  - The mono input is sampled only at pop frames.
  - A stop or start during frame A discards frame B.
- FIFO:
  - Write when full: word dropped, overflow pulses one cycle after.
  - Write and pop in the same cycle when full: both succeed, level unchanged.
  - Write and pop when empty: the pop sees empty (underrun); the write is stored.
  - level is registered and updates one cycle after each write/pop.
- audio_req:
  - Pulses for one cycle after a frame start when state is PRIME or PLAY, level <= REQ_LEVEL, and the request is armed.
  - The pulse disarms it; any accepted write re-arms it.
  - start arms it, so at most one request is outstanding.

Optional Feature:
AUDIO_I2S_LEFT_JUSTIFIED_EN:
- Defined: left-justified format. lrck = 1 for b in [SAMPLE_W, 2*SAMPLE_W-1], so the MSB coincides with the lrck edge.
- Undefined: standard I2S one-bit lead as above.
- Either way, data timing, FIFO behaviour and request behaviour are identical.

Decomposition:
- Package audio_pkg holds:
  - play-state enum {IDLE, PRIME, PLAY};
  - default SAMPLE_W, DEPTH and BCLK_DIV constants;
  - a localparam function for the level width.
- One sub-module, audio_sync_fifo: single-clock FIFO with parameters WIDTH and DEPTH; provides flush, full/empty and level.
- The divider, bit counter, state machine and shifter stay in the top block.

Test Plan:
1. Reset, then default parameters with no start → bclk period 8 cycles, lrck period 256 cycles, sdata = 0, audio_req = 0.
2. start, write 4 words starting 0xA5A5_0F0F → PLAY at the next frame start. Line shows left 0xA5A5 then right 0x0F0F, MSB one BCLK after the lrck edge; with AUDIO_I2S_LEFT_JUSTIFIED_EN, MSB is on the lrck edge.
3. Stereo play draining to level 8 → a single audio_req pulse; no second pulse until a write occurs; after a write and a further drain, another pulse.
4. Drain to empty in PLAY → next frame all zeros, one underrun pulse, state remains PLAY; a following write plays in the next frame.
5. With level 16, 3 writes where the middle one coincides with a frame pop → that write accepted, the other two dropped, 2 overflow pulses, level 16.
6. mono = 1, word 0x1234_5678 → frame 1 plays 0x1234 on both channels, frame 2 plays 0x5678 on both, a single pop; stop mid-frame 1 → IDLE, frame 2 never plays, zeros output.
